rdm_input_buffer_writer: RTL and testbench
==========================================

# rdm_input_buffer_writer

Write-side producer for the rate-dematching (RDM) input buffer. Accepts a serial stream of 6-bit soft LLRs for one combine block of E LLRs and packs them 16 per 96-bit word. Writes the words to consecutive input-buffer addresses starting at a base offset. When the whole block is stored, raises `o_RDM_Data_Request` toward the RDM read FSM and holds it until the reader reports completion.

## Interface
Parameters:
- `LLR_WIDTH`, 6, bits per soft LLR
- `LLRS_PER_WORD`, 16, LLR lanes per buffer word (word width = 96)
- `ADDR_WIDTH`, 16, input-buffer offset address width
- `E_WIDTH`, 14, width of the block-size field

Ports:
- `i_core_clk`  in  1  core clock; all logic on its rising edge
- `i_rx_rst`  in  1  reset, asynchronous, active-high
- `i_Write_Start`  in  1  single-cycle pulse; starts a block, samples E size and base address
- `i_Current_Combine_E01_Size`  in  14  number of LLRs (E) in the block
- `i_Input_Buffer_Base_Address`  in  16  word address of the block's first word
- `i_LLR_Data`  in  6  soft LLR
- `i_LLR_Valid`  in  1  `i_LLR_Data` valid
- `o_LLR_Ready`  out  1  writer accepts an LLR this cycle
- `o_Input_Buffer_Offset_Address`  out  16  write word address
- `o_Input_Buffer_Write_Data`  out  96  packed write word
- `o_Input_Buffer_Write_Enable`  out  1  write strobe, one cycle per word
- `o_RDM_Data_Request`  out  1  block fully stored; RDM may read
- `i_RDM_Read_Done`  in  1  single-cycle pulse from the RDM reader; releases the request
- `o_Busy`  out  1  high in every state except IDLE

## Operation
- FSM states and transitions:
  - IDLE: `i_Write_Start` with E≠0 → FILL. Latch E and base, clear the LLR count k, the lane counter and the pack register. Start with E=0 is ignored.
  - FILL: `o_LLR_Ready`=1. An LLR is accepted when `i_LLR_Valid` and `o_LLR_Ready` are both high on a rising edge.
  - Accepting LLR number E−1 → WR_LAST.
  - WR_LAST: one cycle, no LLRs accepted → REQ.
  - REQ: `o_RDM_Data_Request`=1. `i_RDM_Read_Done` → IDLE.
- Packing: LLR k goes to lane k mod 16, i.e. bits [6·(k mod 16)+5 : 6·(k mod 16)]. Lane 0 is at the LSB.
- Word address = base + floor(k/16), truncated to 16 bits. Wraps 0xFFFF → 0x0000.
- A word is written when lane 15 is accepted, or when LLR E−1 is accepted (final partial word).
- Unfilled upper lanes of the final partial word are written as zero. The pack register is cleared after every write.
- Number of writes per block = ceil(E/16).
- `i_Write_Start` outside IDLE is ignored; latched E and base do not change.
- `i_RDM_Read_Done` outside REQ is ignored.
- `i_LLR_Valid` outside FILL is ignored; no LLR is consumed.
- Reset, including mid-block: returns to IDLE and discards the partial word. No write is issued and all outputs go to their reset values.

## Timing
- Reset value of every output is 0: address, data, write enable, ready, request, busy.
- Write outputs are registered. When the word-completing LLR is accepted at edge n, then for the cycle after edge n:
  - `o_Input_Buffer_Write_Enable`=1
  - address and data hold that word
  - enable drops at edge n+1 unless edge n+1 also completes a word.
- Back-to-back writes are possible every 16 accepted LLRs; the maximum rate is one LLR per cycle.
- Address and data hold their last written value while enable is low.
- `o_LLR_Ready` goes high the cycle after the start edge. It goes low the cycle after LLR E−1 is accepted.
- The final write occurs in the WR_LAST cycle. `o_RDM_Data_Request` rises one cycle later, so the buffer is always written before the request is seen.
- Request is level-held until `i_RDM_Read_Done` is sampled. It drops and `o_Busy` drops at that same edge. A new start is accepted from the next cycle.
- Block latency: start edge → first ready cycle is 1. Last accept → request is 2 cycles.
- Ready does not depend combinationally on valid.

## Test plan
- E=32, base=0, LLR k = k mod 64, valid continuously high:
  - exactly 2 writes, at addresses 0 and 1
  - word 0 lane i = i, word 1 lane i = 16+i
  - request rises 2 cycles after the 32nd accept; drops on the Read_Done pulse.
- E=20, base=0x0100:
  - 2 writes; address 0x0101 carries lanes 0–3 = LLRs 16–19, lanes 4–15 = 0
  - `o_LLR_Ready` low after the 20th accept.
- E=129, random `i_LLR_Valid` gaps (about 50% duty):
  - 9 writes, data identical to the gap-free run
  - no LLR lost or duplicated; write enable never high on two cycles for one word.
- E=1, base=0xFFFF, then E=17, base=0xFFFF:
  - first block: one write at 0xFFFF with lane 0 only
  - second block: writes at 0xFFFF and 0x0000 (wrap).
- `i_Write_Start` pulsed mid-FILL with a different E/base, and Read_Done pulsed in FILL:
  - no effect; the original block completes at its original addresses.
- Reset asserted after 10 LLRs of an E=32 block:
  - all outputs 0 immediately (asynchronous), no write issued
  - a subsequent E=16 block writes exactly one correct word at the new base.

Source files
------------

// File: rtl/rdm_input_buffer_writer.sv
// Packs a serial stream of soft LLRs into wide input-buffer words and raises a
// data request toward the RDM reader once the whole combine block is stored.
module rdm_input_buffer_writer #(
    parameter int LLR_WIDTH     = 6,
    parameter int LLRS_PER_WORD = 16,
    parameter int ADDR_WIDTH    = 16,
    parameter int E_WIDTH       = 14
) (
    input  logic                                 i_core_clk,
    input  logic                                 i_rx_rst,
    input  logic                                 i_Write_Start,
    input  logic [E_WIDTH-1:0]                   i_Current_Combine_E01_Size,
    input  logic [ADDR_WIDTH-1:0]                i_Input_Buffer_Base_Address,
    input  logic [LLR_WIDTH-1:0]                 i_LLR_Data,
    input  logic                                 i_LLR_Valid,
    output logic                                 o_LLR_Ready,
    output logic [ADDR_WIDTH-1:0]                o_Input_Buffer_Offset_Address,
    output logic [LLR_WIDTH*LLRS_PER_WORD-1:0]   o_Input_Buffer_Write_Data,
    output logic                                 o_Input_Buffer_Write_Enable,
    output logic                                 o_RDM_Data_Request,
    input  logic                                 i_RDM_Read_Done,
    output logic                                 o_Busy
);

    localparam int WORD_W = LLR_WIDTH * LLRS_PER_WORD;
    localparam int LANE_W = $clog2(LLRS_PER_WORD);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_WR_LAST,
        S_REQ
    } state_t;

    state_t                  state_q, state_d;
    logic [E_WIDTH-1:0]      e_q, e_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [E_WIDTH-1:0]      k_q, k_d;
    logic [WORD_W-1:0]       pack_q, pack_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]       data_q, data_d;
    logic                    we_q, we_d;

    logic                    accept;
    logic                    last_llr;
    logic                    lane_full;
    logic [LANE_W-1:0]       lane;
    logic [WORD_W-1:0]       pack_ins;

    assign lane      = k_q[LANE_W-1:0];
    assign accept    = (state_q == S_FILL) && i_LLR_Valid;
    assign last_llr  = (k_q == (e_q - E_WIDTH'(1)));
    assign lane_full = (lane == {LANE_W{1'b1}});

    // Current pack register with the incoming LLR dropped into its lane.
    always_comb begin
        pack_ins = pack_q;
        for (int i = 0; i < LLRS_PER_WORD; i++) begin
            if (lane == LANE_W'(i)) begin
                pack_ins[i*LLR_WIDTH +: LLR_WIDTH] = i_LLR_Data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        e_d     = e_q;
        base_d  = base_q;
        k_d     = k_q;
        pack_d  = pack_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_Write_Start && (i_Current_Combine_E01_Size != '0)) begin
                    e_d     = i_Current_Combine_E01_Size;
                    base_d  = i_Input_Buffer_Base_Address;
                    k_d     = '0;
                    pack_d  = '0;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (accept) begin
                    k_d = k_q + E_WIDTH'(1);
                    if (lane_full || last_llr) begin
                        we_d   = 1'b1;
                        data_d = pack_ins;
                        addr_d = base_q + ADDR_WIDTH'(k_q >> LANE_W);
                        pack_d = '0;
                    end else begin
                        pack_d = pack_ins;
                    end
                    if (last_llr) begin
                        state_d = S_WR_LAST;
                    end
                end
            end
            S_WR_LAST: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (i_RDM_Read_Done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
        if (i_rx_rst) begin
            state_q <= S_IDLE;
            e_q     <= '0;
            base_q  <= '0;
            k_q     <= '0;
            pack_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            e_q     <= e_d;
            base_q  <= base_d;
            k_q     <= k_d;
            pack_q  <= pack_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
        end
    end

    assign o_LLR_Ready                   = (state_q == S_FILL);
    assign o_RDM_Data_Request            = (state_q == S_REQ);
    assign o_Busy                        = (state_q != S_IDLE);
    assign o_Input_Buffer_Offset_Address = addr_q;
    assign o_Input_Buffer_Write_Data     = data_q;
    assign o_Input_Buffer_Write_Enable   = we_q;

endmodule

// File: tb/tb_rdm_input_buffer_writer.sv
// Directed bench for the RDM input buffer writer: drives LLR blocks and checks
// every written word, handshake timing and reset behaviour against a small model.
module tb_rdm_input_buffer_writer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [13:0] e_size;
    logic [15:0] base_addr;
    logic [5:0]  llr_data;
    logic        llr_valid;
    logic        llr_ready;
    logic [15:0] wr_addr;
    logic [95:0] wr_data;
    logic        wr_en;
    logic        req;
    logic        rd_done;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int dup_cnt = 0;

    logic [15:0] wq_addr[$];
    logic [95:0] wq_data[$];
    logic        prev_we;
    logic [15:0] prev_addr;

    rdm_input_buffer_writer dut (
        .i_core_clk                    (clk),
        .i_rx_rst                      (rst),
        .i_Write_Start                 (start),
        .i_Current_Combine_E01_Size    (e_size),
        .i_Input_Buffer_Base_Address   (base_addr),
        .i_LLR_Data                    (llr_data),
        .i_LLR_Valid                   (llr_valid),
        .o_LLR_Ready                   (llr_ready),
        .o_Input_Buffer_Offset_Address (wr_addr),
        .o_Input_Buffer_Write_Data     (wr_data),
        .o_Input_Buffer_Write_Enable   (wr_en),
        .o_RDM_Data_Request            (req),
        .i_RDM_Read_Done               (rd_done),
        .o_Busy                        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Write monitor: logs every strobed word, flags a word strobed on two cycles.
    always @(negedge clk) begin
        if (wr_en) begin
            wq_addr.push_back(wr_addr);
            wq_data.push_back(wr_data);
            if (prev_we && (prev_addr == wr_addr)) dup_cnt++;
            $display("write addr=%h data=%h", wr_addr, wr_data);
        end
        prev_we   = wr_en;
        prev_addr = wr_addr;
    end

    function automatic logic [95:0] exp_word(input int e, input int w);
        logic [95:0] d;
        d = '0;
        for (int j = 0; j < 16; j++) begin
            int k;
            k = 16 * w + j;
            if (k < e) d[j*6 +: 6] = 6'(k % 64);
        end
        return d;
    endfunction

    task automatic run_block(input int e, input logic [15:0] base, input bit gaps, input bit inject);
        int k;
        int cyc;
        int nw;
        bit acc;
        wq_addr.delete();
        wq_data.delete();
        @(negedge clk);
        start     = 1'b1;
        e_size    = 14'(e);
        base_addr = base;
        @(negedge clk);
        start = 1'b0;
        chk("ready_after_start", {95'd0, llr_ready}, 96'd1);
        chk("busy_after_start", {95'd0, busy}, 96'd1);
        k   = 0;
        cyc = 0;
        while (k < e && cyc < 3000) begin
            start   = 1'b0;
            rd_done = 1'b0;
            llr_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            llr_data  = 6'(k % 64);
            if (inject && k == 5) begin
                start     = 1'b1;
                e_size    = 14'd7;
                base_addr = 16'h3333;
                rd_done   = 1'b1;
            end
            acc = llr_valid && llr_ready;
            @(posedge clk);
            if (acc) k++;
            cyc++;
            @(negedge clk);
        end
        start     = 1'b0;
        rd_done   = 1'b0;
        llr_valid = 1'b0;
        chk("accept_count", 96'(k), 96'(e));
        // Now one cycle after the last accepting edge: WR_LAST cycle.
        chk("ready_low_after_last", {95'd0, llr_ready}, 96'd0);
        chk("req_low_in_wr_last", {95'd0, req}, 96'd0);
        @(negedge clk);
        chk("req_rise", {95'd0, req}, 96'd1);
        repeat (3) @(negedge clk);
        chk("req_held", {95'd0, req}, 96'd1);
        rd_done = 1'b1;
        @(negedge clk);
        rd_done = 1'b0;
        chk("req_drop", {95'd0, req}, 96'd0);
        chk("busy_drop", {95'd0, busy}, 96'd0);
        nw = (e + 15) / 16;
        chk("write_count", 96'(wq_addr.size()), 96'(nw));
        for (int w = 0; w < nw && w < wq_addr.size(); w++) begin
            chk($sformatf("addr_w%0d", w), {80'd0, wq_addr[w]}, {80'd0, 16'(base + 16'(w))});
            chk($sformatf("data_w%0d", w), wq_data[w], exp_word(e, w));
        end
        chk("no_dup_write", 96'(dup_cnt), 96'd0);
        $display("block E=%0d base=%h writes=%0d", e, base, wq_addr.size());
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        e_size    = '0;
        base_addr = '0;
        llr_data  = '0;
        llr_valid = 1'b0;
        rd_done   = 1'b0;
        prev_we   = 1'b0;
        prev_addr = '0;
        #2;
        chk("rst_ready", {95'd0, llr_ready}, 96'd0);
        chk("rst_req", {95'd0, req}, 96'd0);
        chk("rst_busy", {95'd0, busy}, 96'd0);
        chk("rst_we", {95'd0, wr_en}, 96'd0);
        chk("rst_addr", {80'd0, wr_addr}, 96'd0);
        chk("rst_data", wr_data, 96'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Start with E=0 is ignored.
        @(negedge clk);
        start  = 1'b1;
        e_size = 14'd0;
        @(negedge clk);
        start = 1'b0;
        chk("e0_ignored", {95'd0, busy}, 96'd0);

        run_block(32, 16'h0000, 1'b0, 1'b0);
        run_block(20, 16'h0100, 1'b0, 1'b0);
        run_block(129, 16'h0200, 1'b1, 1'b0);
        run_block(1, 16'hFFFF, 1'b0, 1'b0);
        run_block(17, 16'hFFFF, 1'b0, 1'b0);
        run_block(40, 16'h0500, 1'b0, 1'b1);

        // Reset in the middle of an E=32 block after 10 LLRs.
        wq_addr.delete();
        wq_data.delete();
        @(negedge clk);
        start     = 1'b1;
        e_size    = 14'd32;
        base_addr = 16'h0040;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            llr_valid = 1'b1;
            llr_data  = 6'(k + 1);
            @(negedge clk);
        end
        llr_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_ready", {95'd0, llr_ready}, 96'd0);
        chk("mid_rst_busy", {95'd0, busy}, 96'd0);
        chk("mid_rst_req", {95'd0, req}, 96'd0);
        chk("mid_rst_we", {95'd0, wr_en}, 96'd0);
        chk("mid_rst_addr", {80'd0, wr_addr}, 96'd0);
        chk("mid_rst_data", wr_data, 96'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_no_write", 96'(wq_addr.size()), 96'd0);
        run_block(16, 16'h2000, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
